// File: rtl/genvar_chan_accum_pkg.sv
// Shared types and helpers for the genvar_chan_accum channel bank.
package genvar_accum_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } state_t;

  // Channel index width; a single channel still needs a 1-bit index.
  function automatic int chan_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/genvar_chan_accum_if.sv
// Input words, flush request and drain beat port of genvar_chan_accum.
interface genvar_chan_accum_if
  import genvar_accum_pkg::*;
#(
  parameter int CHANNELS = 4,
  parameter int WIDTH    = 16
);
  localparam int CW = chan_w(CHANNELS);

  logic [CHANNELS-1:0]       in_valid;
  logic [CHANNELS*WIDTH-1:0] in_data;
  logic [CHANNELS-1:0]       in_ready;
  logic                      flush;
  logic                      out_valid;
  logic [CW-1:0]             out_chan;
  logic [WIDTH-1:0]          out_data;
  logic                      out_ovf;
  logic                      out_ready;
  logic                      busy;

  modport master (
    output in_valid, in_data, flush, out_ready,
    input  in_ready, out_valid, out_chan, out_data, out_ovf, busy
  );

  modport slave (
    input  in_valid, in_data, flush, out_ready,
    output in_ready, out_valid, out_chan, out_data, out_ovf, busy
  );

endinterface

// File: rtl/genvar_chan_accum_chan.sv
// One accumulator channel with sticky overflow flag.
// GENVAR_ACCUM_SAT_EN selects saturating instead of wrapping addition.
module genvar_accum_chan #(
  parameter int WIDTH = 16,
  parameter int INIT  = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             add_en,
  input  logic [WIDTH-1:0] add_data,
  input  logic             clr,
  output logic [WIDTH-1:0] acc,
  output logic             ovf
);
  localparam logic [WIDTH-1:0] INIT_V = WIDTH'(INIT);

  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] acc_next;

  assign sum = {1'b0, acc} + {1'b0, add_data};

`ifdef GENVAR_ACCUM_SAT_EN
  assign acc_next = sum[WIDTH] ? {WIDTH{1'b1}} : sum[WIDTH-1:0];
`else
  assign acc_next = sum[WIDTH-1:0];
`endif

  // clr (drain) and add_en (idle) are never asserted together.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc <= INIT_V;
      ovf <= 1'b0;
    end else if (clr) begin
      acc <= INIT_V;
      ovf <= 1'b0;
    end else if (add_en) begin
      acc <= acc_next;
      if (sum[WIDTH]) begin
        ovf <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/genvar_chan_accum.sv
// Multi-channel accumulator bank drained channel-by-channel on flush.
// Build option: GENVAR_ACCUM_SAT_EN (saturating adds, see genvar_accum_chan).
module genvar_chan_accum
  import genvar_accum_pkg::*;
#(
  parameter int CHANNELS = 4,
  parameter int WIDTH    = 16,
  parameter int INIT     = 10
) (
  input logic               clk,
  input logic               rst_n,
  genvar_chan_accum_if.slave bus
);
  localparam int            CW   = chan_w(CHANNELS);
  localparam logic [CW-1:0] LAST = CW'(CHANNELS - 1);

  state_t              state_reg;
  logic [CW-1:0]       ptr_reg;
  logic                idle;
  logic                handshake;
  logic [WIDTH-1:0]    acc_arr [CHANNELS];
  logic [CHANNELS-1:0] ovf_vec;

  assign idle      = (state_reg == IDLE);
  assign handshake = !idle && bus.out_ready;

  for (genvar i = 0; i < CHANNELS; i++) begin : gen
    localparam logic [CW-1:0] IDX = CW'(i);
    logic [WIDTH-1:0] acc;
    logic             ovf;

    genvar_accum_chan #(
      .WIDTH (WIDTH),
      .INIT  (INIT)
    ) u_chan (
      .clk      (clk),
      .rst_n    (rst_n),
      .add_en   (idle && bus.in_valid[i]),
      .add_data (bus.in_data[i*WIDTH +: WIDTH]),
      .clr      (handshake && (ptr_reg == IDX)),
      .acc      (acc),
      .ovf      (ovf)
    );

    assign acc_arr[i] = acc;
    assign ovf_vec[i] = ovf;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      ptr_reg   <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (bus.flush) begin
            state_reg <= DRAIN;
            ptr_reg   <= '0;
          end
        end
        DRAIN: begin
          if (bus.out_ready) begin
            if (ptr_reg == LAST) begin
              state_reg <= IDLE;
              ptr_reg   <= '0;
            end else begin
              ptr_reg <= ptr_reg + CW'(1);
            end
          end
        end
        default: begin
          state_reg <= IDLE;
          ptr_reg   <= '0;
        end
      endcase
    end
  end

  // Outputs depend only on registered state; ptr_reg is 0 whenever idle.
  assign bus.in_ready  = {CHANNELS{idle}};
  assign bus.out_valid = !idle;
  assign bus.busy      = !idle;
  assign bus.out_chan  = ptr_reg;
  assign bus.out_data  = idle ? '0 : acc_arr[ptr_reg];
  assign bus.out_ovf   = idle ? 1'b0 : ovf_vec[ptr_reg];

endmodule

// File: tb/tb_genvar_chan_accum.sv
// Directed bench for genvar_chan_accum with a queue of expected drain beats.
module tb_genvar_chan_accum;
  import genvar_accum_pkg::*;

  localparam int CHANNELS = 4;
  localparam int WIDTH    = 16;
  localparam int INIT     = 10;

  typedef struct packed {
    logic [1:0]  chan;
    logic [15:0] data;
    logic        ovf;
  } beat_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  genvar_chan_accum_if #(.CHANNELS(CHANNELS), .WIDTH(WIDTH)) bus ();

  genvar_chan_accum #(
    .CHANNELS (CHANNELS),
    .WIDTH    (WIDTH),
    .INIT     (INIT)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  beat_t       exp_q[$];
  logic [15:0] m_acc [CHANNELS];
  logic        m_ovf [CHANNELS];
  int          checks = 0;
  int          errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    for (int c = 0; c < CHANNELS; c++) begin
      m_acc[c] = 16'(INIT);
      m_ovf[c] = 1'b0;
    end
  endtask

  task automatic model_add(input int ch, input logic [15:0] d);
    logic [16:0] s;
    s = {1'b0, m_acc[ch]} + {1'b0, d};
    if (s[16]) m_ovf[ch] = 1'b1;
`ifdef GENVAR_ACCUM_SAT_EN
    m_acc[ch] = s[16] ? 16'hFFFF : s[15:0];
`else
    m_acc[ch] = s[15:0];
`endif
  endtask

  task automatic accum(input int ch, input logic [15:0] d);
    bus.in_valid = '0;
    bus.in_data  = '0;
    bus.in_valid[ch] = 1'b1;
    bus.in_data[ch*WIDTH +: WIDTH] = d;
    model_add(ch, d);
    cyc();
    bus.in_valid = '0;
    bus.in_data  = '0;
    $display("accum ch=%0d data=%0h", ch, d);
  endtask

  // Flush, optionally with a same-cycle input word on channel ch.
  task automatic start_flush(input bit with_in, input int ch, input logic [15:0] d);
    bus.flush = 1'b1;
    if (with_in) begin
      bus.in_valid[ch] = 1'b1;
      bus.in_data[ch*WIDTH +: WIDTH] = d;
      model_add(ch, d);
    end
    cyc();
    bus.flush    = 1'b0;
    bus.in_valid = '0;
    bus.in_data  = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      exp_q.push_back('{chan: 2'(c), data: m_acc[c], ovf: m_ovf[c]});
    end
    model_reset();
    check("flush_out_valid", 32'(bus.out_valid), 32'd1);
    check("flush_busy", 32'(bus.busy), 32'd1);
    check("flush_in_ready", 32'(bus.in_ready), 32'd0);
    $display("flush sampled");
  endtask

  task automatic drain_beats(input int n);
    beat_t e;
    bus.out_ready = 1'b1;
    for (int k = 0; k < n; k++) begin
      check("beat_valid", 32'(bus.out_valid), 32'd1);
      if (exp_q.size() == 0) begin
        errors++;
        $error("FAIL beat_queue observed=empty expected=entry");
      end else begin
        e = exp_q.pop_front();
        check("beat_chan", 32'(bus.out_chan), 32'(e.chan));
        check("beat_data", 32'(bus.out_data), 32'(e.data));
        check("beat_ovf", 32'(bus.out_ovf), 32'(e.ovf));
        $display("beat chan=%0d data=%0h ovf=%0b", bus.out_chan, bus.out_data, bus.out_ovf);
      end
      cyc();
    end
    bus.out_ready = 1'b0;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_valid"}, 32'(bus.out_valid), 32'd0);
    check({tag, "_busy"}, 32'(bus.busy), 32'd0);
    check({tag, "_in_ready"}, 32'(bus.in_ready), 32'hF);
    check({tag, "_chan"}, 32'(bus.out_chan), 32'd0);
    check({tag, "_data"}, 32'(bus.out_data), 32'd0);
    check({tag, "_ovf"}, 32'(bus.out_ovf), 32'd0);
  endtask

  task automatic check_accs_init(input string tag);
    check({tag, "_acc0"}, 32'(dut.gen[0].acc), 32'(INIT));
    check({tag, "_acc1"}, 32'(dut.gen[1].acc), 32'(INIT));
    check({tag, "_acc2"}, 32'(dut.gen[2].acc), 32'(INIT));
    check({tag, "_acc3"}, 32'(dut.gen[3].acc), 32'(INIT));
  endtask

  initial begin
    bus.in_valid  = '0;
    bus.in_data   = '0;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b0;
    model_reset();

    // Reset then drain with no inputs
    rst_n = 1'b0;
    cyc();
    cyc();
    rst_n = 1'b1;
    check_idle("reset");
    check_accs_init("reset");
    start_flush(1'b0, 0, '0);
    drain_beats(4);
    check_idle("drain_done");

    // Single-channel sums, then back-to-back flush
    accum(1, 16'd5);
    check("acc1_after_5", 32'(dut.gen[1].acc), 32'd15);
    accum(1, 16'd7);
    check("acc1_after_7", 32'(dut.gen[1].acc), 32'd22);
    start_flush(1'b0, 0, '0);
    drain_beats(4);
    start_flush(1'b0, 0, '0);
    drain_beats(4);
    check_idle("second_drain");

    // Backpressure at ptr 1 with ignored flush and ignored input
    accum(1, 16'd100);
    start_flush(1'b0, 0, '0);
    drain_beats(1);
    bus.flush = 1'b1;
    bus.in_valid[3] = 1'b1;
    bus.in_data[3*WIDTH +: WIDTH] = 16'd100;
    for (int k = 0; k < 3; k++) begin
      check("stall_valid", 32'(bus.out_valid), 32'd1);
      check("stall_chan", 32'(bus.out_chan), 32'd1);
      check("stall_data", 32'(bus.out_data), 32'd110);
      check("stall_in_ready", 32'(bus.in_ready), 32'd0);
      $display("stall cycle %0d chan=%0d data=%0h", k, bus.out_chan, bus.out_data);
      cyc();
    end
    bus.flush    = 1'b0;
    bus.in_valid = '0;
    bus.in_data  = '0;
    drain_beats(3);
    check_idle("after_stall");

    // Overflow on channel 0
    accum(0, 16'hFFFF);
`ifdef GENVAR_ACCUM_SAT_EN
    check("ovf_acc0", 32'(dut.gen[0].acc), 32'hFFFF);
`else
    check("ovf_acc0", 32'(dut.gen[0].acc), 32'd9);
`endif
    start_flush(1'b0, 0, '0);
    drain_beats(4);

    // Same-cycle flush and input on channel 2
    start_flush(1'b1, 2, 16'd3);
    drain_beats(4);
    check_idle("same_cycle");

    // Reset mid-drain after two handshakes
    accum(3, 16'd40);
    start_flush(1'b0, 0, '0);
    drain_beats(2);
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    exp_q.delete();
    model_reset();
    check_idle("mid_reset");
    check_accs_init("mid_reset");
    start_flush(1'b0, 0, '0);
    drain_beats(4);
    check_idle("final");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
